// File: rtl/xpt_cfg_tx.sv
// xpt_cfg_tx
//   Builds a 60-byte crosspoint configuration frame and streams it as eight
//   64-bit AXI-stream beats towards a 10G MAC TX FIFO. The remote config
//   parser loads the 16 select bytes carried in the frame into its select
//   registers.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   start             request one frame (sampled every cycle)
//   select[127:0]     select byte i on [8i+7:8i], captured at frame launch
//   dest_mac, src_mac MAC addresses, captured at launch, [47:40] sent first
//   m_axis_*          AXI-stream master (tuser tied low)
//   busy              frame in progress or request pending (registered)
//   frame_count       completed frames, wraps at 16 bits
module xpt_cfg_tx #(
  parameter logic [15:0] ETH_TYPE = 16'h8099
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] select,
  input  logic [47:0]  dest_mac,
  input  logic [47:0]  src_mac,
  output logic [63:0]  m_axis_tdata,
  output logic [7:0]   m_axis_tkeep,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic         m_axis_tuser,
  output logic         busy,
  output logic [15:0]  frame_count
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [2:0] LAST_BEAT = 3'd7;

  // Byte n of the frame (n = 0..63). Bytes past the select field are zero
  // padding so the payload exceeds 16 bytes: the receiver drops a select
  // word that arrives together with tlast.
  function automatic logic [7:0] frame_byte(input int unsigned n,
                                            input logic [127:0] sel,
                                            input logic [47:0]  dst,
                                            input logic [47:0]  src);
    logic [7:0] b;
    b = 8'h00;
    if (n < 6)        b = dst[8*(5-n) +: 8];
    else if (n < 12)  b = src[8*(11-n) +: 8];
    else if (n == 12) b = ETH_TYPE[15:8];
    else if (n == 13) b = ETH_TYPE[7:0];
    else if (n < 30)  b = sel[8*(n-14) +: 8];
    return b;
  endfunction

  // Beat idx of the frame; frame byte 8*idx+k goes on lane k.
  function automatic logic [63:0] beat_data(input logic [2:0]   idx,
                                            input logic [127:0] sel,
                                            input logic [47:0]  dst,
                                            input logic [47:0]  src);
    logic [63:0] d;
    d = '0;
    for (int unsigned k = 0; k < 8; k++)
      d[8*k +: 8] = frame_byte({29'd0, idx} * 8 + k, sel, dst, src);
    return d;
  endfunction

  state_t         state_q, state_d;
  logic [2:0]     beat_q, beat_d;
  logic           pending_q, pending_d;
  logic           busy_q, busy_d;
  logic [15:0]    count_q, count_d;
  logic [63:0]    tdata_q, tdata_d;
  logic [7:0]     tkeep_q, tkeep_d;
  logic           tlast_q, tlast_d;
  logic           load;
  logic [127:0]   sel_q;
  logic [47:0]    dst_q, src_q;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    pending_d = pending_q;
    count_d   = count_q;
    tdata_d   = tdata_q;
    tkeep_d   = tkeep_q;
    tlast_d   = tlast_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SEND;
          beat_d  = 3'd0;
          tdata_d = beat_data(3'd0, select, dest_mac, src_mac);
          tkeep_d = 8'hFF;
          tlast_d = 1'b0;
        end
      end
      SEND: begin
        if (start) pending_d = 1'b1;
        if (m_axis_tready) begin
          if (beat_q == LAST_BEAT) begin
            count_d = count_q + 16'd1;
            if (pending_q || start) begin
              // Relaunch straight from the live inputs: frames go back-to-back.
              load      = 1'b1;
              pending_d = 1'b0;
              beat_d    = 3'd0;
              tdata_d   = beat_data(3'd0, select, dest_mac, src_mac);
              tkeep_d   = 8'hFF;
              tlast_d   = 1'b0;
            end else begin
              state_d = IDLE;
              tdata_d = '0;
              tkeep_d = '0;
              tlast_d = 1'b0;
            end
          end else begin
            beat_d  = beat_q + 3'd1;
            tdata_d = beat_data(beat_d, sel_q, dst_q, src_q);
            tkeep_d = (beat_d == LAST_BEAT) ? 8'h0F : 8'hFF;
            tlast_d = (beat_d == LAST_BEAT);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SEND) || pending_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= 3'd0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= 16'd0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tlast_q   <= tlast_d;
    end
  end

  // Frame fields are frozen at launch so mid-frame input changes are ignored.
  always_ff @(posedge clk) begin
    if (load) begin
      sel_q <= select;
      dst_q <= dest_mac;
      src_q <= src_mac;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tuser  = 1'b0;
  assign busy          = busy_q;
  assign frame_count   = count_q;

endmodule
